// File: rtl/handshake_monitor_pkg.sv
// Shared types for the multi-channel ready/valid handshake monitor.
package handshake_monitor_pkg;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_DROP        = 2'd1,
        ERR_DATA_CHANGE = 2'd2,
        ERR_TIMEOUT     = 2'd3
    } err_code_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } chan_state_t;

    function automatic logic is_error(input err_code_t code);
        return (code != ERR_NONE);
    endfunction

endpackage

// File: rtl/hs_channel_checker.sv
// Protocol checker for one ready/valid channel: tracks one stall episode at a
// time and flags the error seen this cycle combinationally on err.
module hs_channel_checker
    import handshake_monitor_pkg::*;
#(
    parameter int DATA_W  = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output err_code_t         err,
    output logic [CNT_W-1:0]  count
);

    localparam int               SC_W       = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0]  STALL_MAX  = SC_W'(TIMEOUT);
    localparam logic [SC_W-1:0]  STALL_LAST = SC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    chan_state_t       state_q, state_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [SC_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SC_W-1:0]   stall_inc_s;
    logic [CNT_W-1:0]  count_inc_s;

    assign stall_inc_s = (stall_q == STALL_MAX) ? STALL_MAX : stall_q + SC_W'(1);
    assign count_inc_s = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);

    // State, capture, stall and transfer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cap_q   <= {DATA_W{1'b0}};
            stall_q <= {SC_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else if (clear) begin
            state_q <= ST_IDLE;
            cap_q   <= {DATA_W{1'b0}};
            stall_q <= {SC_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            stall_q <= stall_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; capture always follows data so a changed payload is recaptured.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        stall_d = stall_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (valid && ready) begin
                    count_d = count_inc_s;
                end else if (valid) begin
                    state_d = ST_WAIT;
                    cap_d   = data;
                    stall_d = SC_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!valid) begin
                    state_d = ST_IDLE;
                    stall_d = {SC_W{1'b0}};
                end else if (ready) begin
                    state_d = ST_IDLE;
                    cap_d   = data;
                    stall_d = {SC_W{1'b0}};
                    count_d = count_inc_s;
                end else begin
                    cap_d   = data;
                    stall_d = stall_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                stall_d = {SC_W{1'b0}};
            end
        endcase
    end

    // Error classification in priority order; timeout fires once as the counter reaches TIMEOUT.
    always_comb begin
        err = ERR_NONE;
        case (state_q)
            ST_WAIT: begin
                if (!valid) begin
                    err = ERR_DROP;
                end else if (data != cap_q) begin
                    err = ERR_DATA_CHANGE;
                end else if (!ready && (stall_q == STALL_LAST)) begin
                    err = ERR_TIMEOUT;
                end else begin
                    err = ERR_NONE;
                end
            end
            ST_IDLE: err = ERR_NONE;
            default: err = ERR_NONE;
        endcase
    end

    assign count = count_q;

endmodule

// File: rtl/handshake_monitor.sv
// Passive monitor over NUM_CH ready/valid channels: per-channel checkers plus
// registered sticky flags, error pulse and first-error capture.
module handshake_monitor
    import handshake_monitor_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESET,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        valid,
    input  logic [NUM_CH-1:0]        ready,
    input  logic [NUM_CH*DATA_W-1:0] data,
    output logic [NUM_CH*CNT_W-1:0]  xfer_count,
    output logic [NUM_CH-1:0]        err_sticky,
    output logic                     err_pulse,
    output logic                     first_err_valid,
    output logic [CH_W-1:0]          first_err_chan,
    output logic [1:0]               first_err_code
);

    err_code_t         ch_err_s [NUM_CH];
    logic [NUM_CH-1:0] err_hit_s;
    logic [CH_W-1:0]   enc_chan_s;
    err_code_t         enc_code_s;

    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic              pulse_q, pulse_d;
    logic              fv_q, fv_d;
    logic [CH_W-1:0]   fchan_q, fchan_d;
    err_code_t         fcode_q, fcode_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hs_channel_checker #(
            .DATA_W  (DATA_W),
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_chk (
            .clk   (CLK),
            .rst   (ASYNCRESET),
            .clear (clear),
            .valid (valid[g]),
            .ready (ready[g]),
            .data  (data[g*DATA_W +: DATA_W]),
            .err   (ch_err_s[g]),
            .count (xfer_count[g*CNT_W +: CNT_W])
        );
        assign err_hit_s[g] = is_error(ch_err_s[g]);
    end

    // Priority encoder: scanning downward lets the lowest erroring channel win.
    always_comb begin
        enc_chan_s = {CH_W{1'b0}};
        enc_code_s = ERR_NONE;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            enc_chan_s = err_hit_s[i] ? CH_W'(i) : enc_chan_s;
            enc_code_s = err_hit_s[i] ? ch_err_s[i] : enc_code_s;
        end
    end

    // Next values for sticky flags, pulse and first-error capture.
    always_comb begin
        sticky_d = sticky_q | err_hit_s;
        pulse_d  = |err_hit_s;
        if (!fv_q && (|err_hit_s)) begin
            fv_d    = 1'b1;
            fchan_d = enc_chan_s;
            fcode_d = enc_code_s;
        end else begin
            fv_d    = fv_q;
            fchan_d = fchan_q;
            fcode_d = fcode_q;
        end
    end

    // Error reporting registers.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            sticky_q <= {NUM_CH{1'b0}};
            pulse_q  <= 1'b0;
            fv_q     <= 1'b0;
            fchan_q  <= {CH_W{1'b0}};
            fcode_q  <= ERR_NONE;
        end else if (clear) begin
            sticky_q <= {NUM_CH{1'b0}};
            pulse_q  <= 1'b0;
            fv_q     <= 1'b0;
            fchan_q  <= {CH_W{1'b0}};
            fcode_q  <= ERR_NONE;
        end else begin
            sticky_q <= sticky_d;
            pulse_q  <= pulse_d;
            fv_q     <= fv_d;
            fchan_q  <= fchan_d;
            fcode_q  <= fcode_d;
        end
    end

    assign err_sticky      = sticky_q;
    assign err_pulse       = pulse_q;
    assign first_err_valid = fv_q;
    assign first_err_chan  = fchan_q;
    assign first_err_code  = fcode_q;

endmodule

// File: tb/tb_handshake_monitor.sv
// Directed bench for handshake_monitor: a 3-channel instance plus a 1-channel
// CNT_W=2 instance for counter saturation.
module tb_handshake_monitor;

    logic        CLK = 1'b0;
    logic        ASYNCRESET;
    logic        clear;
    logic [2:0]  valid;
    logic [2:0]  ready;
    logic [14:0] data;
    logic [47:0] xfer_count;
    logic [2:0]  err_sticky;
    logic        err_pulse;
    logic        first_err_valid;
    logic [1:0]  first_err_chan;
    logic [1:0]  first_err_code;

    logic        s_clear;
    logic [0:0]  s_valid;
    logic [0:0]  s_ready;
    logic [4:0]  s_data;
    logic [1:0]  s_count;
    logic [0:0]  s_sticky;
    logic        s_pulse;
    logic        s_fv;
    logic [0:0]  s_fchan;
    logic [1:0]  s_fcode;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 CLK = ~CLK;

    handshake_monitor u_dut (
        .CLK             (CLK),
        .ASYNCRESET      (ASYNCRESET),
        .clear           (clear),
        .valid           (valid),
        .ready           (ready),
        .data            (data),
        .xfer_count      (xfer_count),
        .err_sticky      (err_sticky),
        .err_pulse       (err_pulse),
        .first_err_valid (first_err_valid),
        .first_err_chan  (first_err_chan),
        .first_err_code  (first_err_code)
    );

    handshake_monitor #(.NUM_CH(1), .DATA_W(5), .CNT_W(2), .TIMEOUT(8)) u_sat (
        .CLK             (CLK),
        .ASYNCRESET      (ASYNCRESET),
        .clear           (s_clear),
        .valid           (s_valid),
        .ready           (s_ready),
        .data            (s_data),
        .xfer_count      (s_count),
        .err_sticky      (s_sticky),
        .err_pulse       (s_pulse),
        .first_err_valid (s_fv),
        .first_err_chan  (s_fchan),
        .first_err_code  (s_fcode)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic r, input logic [4:0] d);
        valid[ch]        = v;
        ready[ch]        = r;
        data[ch*5 +: 5]  = d;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        ASYNCRESET = 1'b1;
        clear      = 1'b0;
        valid      = 3'b000;
        ready      = 3'b000;
        data       = 15'h0000;
        s_clear    = 1'b0;
        s_valid    = 1'b0;
        s_ready    = 1'b0;
        s_data     = 5'h00;
        repeat (2) tick();
        chk("rst_count",  xfer_count, 64'h0);
        chk("rst_sticky", err_sticky, 64'h0);
        chk("rst_pulse",  err_pulse, 64'h0);
        chk("rst_fv",     first_err_valid, 64'h0);
        chk("rst_fcode",  first_err_code, 64'h0);
        ASYNCRESET = 1'b0;
        tick();

        // back-to-back transfers on ch0
        set_ch(0, 1'b1, 1'b1, 5'h0A);
        tick();
        chk("b2b_pulse1", err_pulse, 64'h0);
        chk("b2b_cnt1",   xfer_count[15:0], 64'd1);
        set_ch(0, 1'b1, 1'b1, 5'h0B);
        tick();
        chk("b2b_pulse2", err_pulse, 64'h0);
        set_ch(0, 1'b0, 1'b0, 5'h00);
        tick();
        chk("b2b_cnt2",   xfer_count[15:0], 64'd2);
        chk("b2b_sticky", err_sticky, 64'h0);
        chk("b2b_pulse3", err_pulse, 64'h0);

        // DROP on ch1
        set_ch(1, 1'b1, 1'b0, 5'h04);
        tick();
        chk("drop_pulse_a", err_pulse, 64'h0);
        tick();
        chk("drop_pulse_b", err_pulse, 64'h0);
        set_ch(1, 1'b0, 1'b0, 5'h04);
        tick();
        chk("drop_pulse",  err_pulse, 64'h1);
        chk("drop_sticky", err_sticky, 64'h2);
        chk("drop_fv",     first_err_valid, 64'h1);
        chk("drop_fchan",  first_err_chan, 64'd1);
        chk("drop_fcode",  first_err_code, 64'd1);
        chk("drop_cnt1",   xfer_count[31:16], 64'd0);
        tick();
        chk("drop_pulse_off", err_pulse, 64'h0);
        do_clear();
        chk("clr1_sticky", err_sticky, 64'h0);
        chk("clr1_count",  xfer_count, 64'h0);

        // DATA_CHANGE on ch2, completing afterwards
        set_ch(2, 1'b1, 1'b0, 5'h11);
        tick();
        set_ch(2, 1'b1, 1'b0, 5'h12);
        tick();
        chk("dc_pulse",  err_pulse, 64'h1);
        chk("dc_sticky", err_sticky, 64'h4);
        chk("dc_fchan",  first_err_chan, 64'd2);
        chk("dc_fcode",  first_err_code, 64'd2);
        set_ch(2, 1'b1, 1'b1, 5'h12);
        tick();
        chk("dc_pulse_off", err_pulse, 64'h0);
        chk("dc_cnt2",      xfer_count[47:32], 64'd1);
        set_ch(2, 1'b0, 1'b0, 5'h00);
        tick();
        do_clear();

        // TIMEOUT on ch0: 12 stall cycles, pulse exactly once after the 8th
        set_ch(0, 1'b1, 1'b0, 5'h03);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (err_pulse === 1'b1) pulses++;
            chk($sformatf("to_pulse_%0d", k), err_pulse, (k == 8) ? 64'h1 : 64'h0);
            if (k == 8) begin
                chk("to_fcode", first_err_code, 64'd3);
                chk("to_fchan", first_err_chan, 64'd0);
            end
        end
        chk("to_npulses", pulses, 64'd1);
        set_ch(0, 1'b1, 1'b1, 5'h03);
        tick();
        chk("to_cnt0",   xfer_count[15:0], 64'd1);
        chk("to_sticky", err_sticky, 64'h1);
        set_ch(0, 1'b0, 1'b0, 5'h00);
        tick();
        do_clear();

        // simultaneous DROP on ch2 and DATA_CHANGE on ch1
        set_ch(1, 1'b1, 1'b0, 5'h01);
        set_ch(2, 1'b1, 1'b0, 5'h02);
        tick();
        set_ch(1, 1'b1, 1'b0, 5'h1F);
        set_ch(2, 1'b0, 1'b0, 5'h02);
        tick();
        chk("sim_pulse",  err_pulse, 64'h1);
        chk("sim_sticky", err_sticky, 64'h6);
        chk("sim_fchan",  first_err_chan, 64'd1);
        chk("sim_fcode",  first_err_code, 64'd2);
        set_ch(1, 1'b1, 1'b1, 5'h1F);
        set_ch(0, 1'b1, 1'b0, 5'h00);
        tick();
        chk("sim_pulse_off", err_pulse, 64'h0);
        set_ch(1, 1'b0, 1'b0, 5'h00);
        set_ch(0, 1'b0, 1'b0, 5'h00);
        tick();
        chk("late_pulse",  err_pulse, 64'h1);
        chk("late_sticky", err_sticky, 64'h7);
        chk("late_fchan",  first_err_chan, 64'd1);
        chk("late_fcode",  first_err_code, 64'd2);
        chk("late_cnt1",   xfer_count[31:16], 64'd1);
        do_clear();
        chk("clr_count",  xfer_count, 64'h0);
        chk("clr_sticky", err_sticky, 64'h0);
        chk("clr_fv",     first_err_valid, 64'h0);
        chk("clr_fchan",  first_err_chan, 64'h0);
        chk("clr_fcode",  first_err_code, 64'h0);
        chk("clr_pulse",  err_pulse, 64'h0);

        // saturation with CNT_W=2
        s_valid = 1'b1;
        s_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            s_data = 5'(k);
            tick();
            chk($sformatf("sat_cnt_%0d", k), s_count, (k < 3) ? 64'(k) : 64'd3);
        end
        s_valid = 1'b0;
        s_ready = 1'b0;
        chk("sat_sticky", s_sticky, 64'h0);

        // async reset in the middle of a stall
        set_ch(1, 1'b1, 1'b1, 5'h05);
        tick();
        set_ch(1, 1'b0, 1'b0, 5'h00);
        set_ch(2, 1'b1, 1'b0, 5'h07);
        tick();
        set_ch(2, 1'b0, 1'b0, 5'h07);
        tick();
        chk("pre_sticky", err_sticky, 64'h4);
        chk("pre_cnt1",   xfer_count[31:16], 64'd1);
        set_ch(0, 1'b1, 1'b0, 5'h09);
        tick();
        tick();
        #2;
        ASYNCRESET = 1'b1;
        #1;
        chk("ar_count",  xfer_count, 64'h0);
        chk("ar_sticky", err_sticky, 64'h0);
        chk("ar_fv",     first_err_valid, 64'h0);
        chk("ar_satcnt", s_count, 64'h0);
        set_ch(0, 1'b0, 1'b0, 5'h00);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("ar_pulse_%0d", k), err_pulse, 64'h0);
            chk($sformatf("ar_sticky_%0d", k), err_sticky, 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/handshake_monitor.md
Name: handshake_monitor

Overview:
- Parametrised, synthesizable successor to the single-handshake RTL monitor.
- Watches NUM_CH independent ready/valid channels, each with a DATA_W payload. Per channel it checks three protocol rules:
  - valid held until ready;
  - payload stable while stalled;
  - stall bounded by TIMEOUT cycles.
- Counts completed transfers per channel, keeps sticky per-channel error flags, and captures the first error seen.
- Bound alongside the DUT as a passive observer; it drives nothing into the DUT.

Parameters:
- NUM_CH, 3: number of monitored channels (≥1).
- DATA_W, 5: payload width per channel.
- CNT_W, 16: width of each transfer counter.
- TIMEOUT, 8: stall cycles (valid && !ready) that trigger a timeout error (≥2).

Ports:
- CLK  input  1  clock, rising edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of counters, flags, capture and FSMs.
- valid  input  NUM_CH  per-channel valid.
- ready  input  NUM_CH  per-channel ready.
- data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- xfer_count  output  NUM_CH*CNT_W  per-channel saturating count of valid&&ready cycles.
- err_sticky  output  NUM_CH  bit i set on any error on channel i.
- err_pulse  output  1  high for one cycle after any error is detected on any channel.
- first_err_valid  output  1  first error has been captured.
- first_err_chan  output  max(1,$clog2(NUM_CH))  channel of the first error.
- first_err_code  output  2  code of the first error: 1 = DROP, 2 = DATA_CHANGE, 3 = TIMEOUT.

Behaviour:
- Reset: ASYNCRESET=1 forces all outputs to 0, all channel FSMs to IDLE and all stall counters to 0.
- clear=1: has the same effect synchronously and overrides every event in that cycle.
- Per-channel FSM, IDLE state:
  - valid&&ready → count++, stay IDLE.
  - valid&&!ready → go to WAIT, capture data, stall_cnt=1.
- Per-channel FSM, WAIT state. Checks apply in priority order; at most one error per channel per cycle:
  - !valid → DROP error; go to IDLE.
  - valid && data≠captured → DATA_CHANGE error; recapture data. Then:
    - if ready: count++, go to IDLE;
    - otherwise stay in WAIT and increment stall_cnt.
  - valid&&ready, data unchanged → count++, go to IDLE.
  - valid&&!ready, data unchanged → stall_cnt++. When the incremented value equals TIMEOUT, raise TIMEOUT error exactly once per WAIT episode. stall_cnt saturates at TIMEOUT.
- Error timing:
  - All error outputs are registered: 1-cycle latency from the detecting edge.
  - err_pulse=1 in the cycle after any channel detects an error.
  - err_sticky[i] sets on the same cycle as err_pulse.
- First-error capture:
  - Loads only while first_err_valid=0.
  - Simultaneous errors on several channels: the lowest index wins.
  - Held until clear or reset.
- Counters: xfer_count saturates at 2^CNT_W−1 and never wraps.
- Timing corner cases:
  - A transfer completing on the same cycle as the TIMEOUT-th stall is impossible by definition, since ready=1 ends the stall.
  - A DATA_CHANGE on the completing cycle is still reported, and the transfer is still counted.
- Reset asserted mid-WAIT: the episode is discarded; no error is reported.

Decomposition:
- Package handshake_monitor_pkg:
  - err_code_t enum {NONE=0, DROP=1, DATA_CHANGE=2, TIMEOUT=3};
  - chan_state_t enum {IDLE, WAIT}.
- Sub-module hs_channel_checker, instantiated NUM_CH times via generate. It contains:
  - FSM, capture register, stall counter, transfer counter;
  - outputs err_code_t err and count.
- The top level holds the priority encoder, the sticky/first-error registers and err_pulse.

Test Plan:
- Two back-to-back transfers: ch0 valid=ready=1 for 2 cycles with data 5'h0A, 5'h0B → xfer_count[0]=2, err_sticky=0, err_pulse never asserted.
- DROP: ch1 valid=1, ready=0 for 2 cycles, then valid=0 → err_pulse one cycle, err_sticky=3'b010, first_err_chan=1, first_err_code=1, xfer_count[1]=0.
- DATA_CHANGE: ch2 stalls with data 5'h11, changes to 5'h12, then ready=1 → code 2 on ch2, xfer_count[2]=1.
- TIMEOUT=8 with 12 stall cycles on ch0 → exactly one err_pulse, 8 cycles after stall start + 1, code 3; ready=1 afterward gives count 1.
- Simultaneous DROP on ch2 and DATA_CHANGE on ch1 in the same cycle → err_sticky=3'b110, first_err_chan=1, first_err_code=2. A later error on ch0 leaves the capture unchanged. clear then zeroes everything.
- CNT_W=2 with 5 transfers → xfer_count saturates at 3. ASYNCRESET pulsed mid-stall → all outputs 0 immediately, with no error afterward.
